// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t    : loader FSM encoding
//   *_DEF      : default geometry (9-bit instruction words, 256-entry memory)
package prog_loader_pkg;

  localparam int IW_DEF    = 9;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Stream-in / memory-write bundle of the instruction loader.
//   in_valid, in_data : host word stream (header first, then instructions)
//   in_ready          : loader can accept a word this cycle
//   imem_we/addr/wdata: registered write port into the instruction memory
// master = host/memory side, slave = loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF
);

  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Instruction-memory loader: takes a length header plus that many words over
// a valid/ready stream, writes them to consecutive addresses from 0, then
// pulses cpu_start and releases cpu_hold.
//
// Ports:
//   CLK        : system clock
//   init       : asynchronous active-high reset
//   load_start : one-cycle load request (honoured in IDLE, DONE, ERR)
//   bus        : stream input + registered memory write port (slave side)
//   cpu_hold   : keeps the CPU in reset; low only in DONE
//   cpu_start  : one-cycle pulse after a successful load
//   busy       : in LEN, LOAD or START
//   done / err : load finished / header rejected, held until next load_start
//   count      : words written in the current load
//
// state | meaning
// IDLE  | after reset, waiting for load_start
// LEN   | accepting the length header
// LOAD  | accepting and writing instruction words
// START | one cycle, cpu_start asserted
// DONE  | load complete, CPU released
// ERR   | header was 0 or larger than DEPTH
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          init,
  input  logic          load_start,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          cpu_start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam int          CW        = AW + 1;
  // Header compared one bit wider so DEPTH itself is representable.
  localparam logic [IW:0] DEPTH_HDR = (IW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   remaining;
  logic          xfer;
  logic          hdr_bad;
  logic          restart;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign hdr_bad = (bus.in_data == '0) || ({1'b0, bus.in_data} > DEPTH_HDR);
  assign restart = load_start &&
                   ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  // State register
  always_ff @(posedge CLK or posedge init) begin
    if (init) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (restart) state_d = LEN;
      LEN:   if (xfer)    state_d = hdr_bad ? ERR : LOAD;
      LOAD:  if (xfer && (remaining == CW'(1))) state_d = START;
      START: state_d = DONE;
      DONE:  if (restart) state_d = LEN;
      ERR:   if (restart) state_d = LEN;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.in_ready = 1'b0;
    cpu_hold     = 1'b1;
    cpu_start    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      LEN:   begin bus.in_ready = 1'b1; busy = 1'b1; end
      LOAD:  begin bus.in_ready = 1'b1; busy = 1'b1; end
      START: begin cpu_start = 1'b1; busy = 1'b1; end
      DONE:  begin done = 1'b1; cpu_hold = 1'b0; end
      ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word counter, remaining down-counter, registered write port.
  // remaining is only loaded on an accepted header, so L <= DEPTH <= 2**AW
  // keeps every write address inside the array.
  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      count          <= '0;
      remaining      <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (restart || (state_q == IDLE)) count <= '0;
      case (state_q)
        LEN: if (xfer && !hdr_bad) remaining <= CW'(bus.in_data);
        LOAD: if (xfer) begin
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= count[AW-1:0];
          bus.imem_wdata <= bus.in_data;
          count          <= count + CW'(1);
          remaining      <= remaining - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int IW    = 9;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        init;
  logic        load_start;
  logic        cpu_hold, cpu_start, busy, done, err;
  logic [AW:0] count;

  prog_loader_if #(.IW(IW), .AW(AW)) bus ();

  prog_loader #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .init       (init),
    .load_start (load_start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int wr_base  = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write seen on the memory port must match the next
  // expected {addr, data} pushed by the stimulus.
  always @(negedge CLK) begin
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write",
               bus.imem_addr, bus.imem_wdata);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", 32'({bus.imem_addr, bus.imem_wdata}), 32'(exp_w));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step(1);
    load_start = 1'b0;
  endtask

  // Present a word and hold it until a handshake edge has passed.
  task automatic send(input logic [IW-1:0] w);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = bus.in_ready;
      step(1);
      if (rdy === 1'b1) ok = 1'b1;
    end
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL send_timeout observed in_ready=0 expected handshake for word 0x%0h", w);
    end
  endtask

  task automatic expect_write(input int addr, input logic [IW-1:0] w);
    exp_q.push_back({AW'(addr), w});
  endtask

  initial begin
    logic [IW-1:0] w;
    init         = 1'b0;
    load_start   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Asynchronous reset, checked before the first clock edge
    #2 init = 1'b1;
    #1;
    check("rst_cpu_hold",  32'(cpu_hold), 32'd1);
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_imem_we",   32'(bus.imem_we), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata",     32'(bus.imem_wdata), 32'd0);
    check("rst_cpu_start", 32'(cpu_start), 32'd0);
    check("rst_done_err",  32'({done, err, busy}), 32'd0);
    check("rst_count",     32'(count), 32'd0);
    step(2);
    init = 1'b0;
    step(1);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Nominal 3-word load with continuous valid
    wr_base = wr_cnt;
    pulse_start();
    check("len_busy", 32'(busy), 32'd1);
    expect_write(0, 9'h101);
    expect_write(1, 9'h0A2);
    expect_write(2, 9'h1FF);
    send(9'd3);
    send(9'h101);
    send(9'h0A2);
    send(9'h1FF);
    bus.in_valid = 1'b0;
    check("nom_cpu_start", 32'(cpu_start), 32'd1);
    check("nom_start_hold", 32'(cpu_hold), 32'd1);
    check("nom_start_ready", 32'(bus.in_ready), 32'd0);
    step(1);
    check("nom_done", 32'(done), 32'd1);
    check("nom_start_pulse", 32'(cpu_start), 32'd0);
    check("nom_hold_release", 32'(cpu_hold), 32'd0);
    check("nom_count", 32'(count), 32'd3);
    check("nom_busy", 32'(busy), 32'd0);
    check("nom_writes", 32'(wr_cnt - wr_base), 32'd3);

    // Reload from DONE; a load_start mid-load must not restart it.
    // Stream stalls for two cycles between the words.
    wr_base = wr_cnt;
    pulse_start();
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_count", 32'(count), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    expect_write(0, 9'h055);
    expect_write(1, 9'h0AA);
    send(9'd2);
    send(9'h055);
    bus.in_valid = 1'b0;
    bus.in_data  = 9'h1EE;
    pulse_start();
    step(1);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_count", 32'(count), 32'd1);
    send(9'h0AA);
    bus.in_valid = 1'b0;
    step(1);
    check("stall_done", 32'(done), 32'd1);
    check("stall_count_end", 32'(count), 32'd2);
    check("stall_writes", 32'(wr_cnt - wr_base), 32'd2);

    // Header 0 rejected
    wr_base = wr_cnt;
    pulse_start();
    send(9'd0);
    bus.in_valid = 1'b0;
    check("hdr0_err", 32'(err), 32'd1);
    check("hdr0_hold", 32'(cpu_hold), 32'd1);
    check("hdr0_ready", 32'(bus.in_ready), 32'd0);
    check("hdr0_busy", 32'(busy), 32'd0);

    // Header DEPTH+1 rejected
    pulse_start();
    check("err_clear", 32'(err), 32'd0);
    send(9'd257);
    bus.in_valid = 1'b0;
    step(1);
    check("hdr257_err", 32'(err), 32'd1);
    check("hdr_err_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Recovery with header 1
    pulse_start();
    expect_write(0, 9'h123);
    send(9'd1);
    send(9'h123);
    bus.in_valid = 1'b0;
    check("rec_cpu_start", 32'(cpu_start), 32'd1);
    step(1);
    check("rec_done", 32'(done), 32'd1);
    check("rec_err", 32'(err), 32'd0);
    check("rec_count", 32'(count), 32'd1);

    // Full-depth load, last write at 0xFF
    wr_base = wr_cnt;
    pulse_start();
    send(9'd256);
    for (int i = 0; i < DEPTH; i++) begin
      w = IW'(i * 37 + 5);
      expect_write(i, w);
      send(w);
    end
    bus.in_valid = 1'b0;
    check("full_cpu_start", 32'(cpu_start), 32'd1);
    step(1);
    check("full_done", 32'(done), 32'd1);
    check("full_count", 32'(count), 32'd256);
    check("full_writes", 32'(wr_cnt - wr_base), 32'd256);

    // Abort after 2 of 5 words; valid stays high through and after reset
    wr_base = wr_cnt;
    pulse_start();
    expect_write(0, 9'h011);
    expect_write(1, 9'h022);
    send(9'd5);
    send(9'h011);
    send(9'h022);
    bus.in_data = 9'h033;
    @(negedge CLK);
    #2 init = 1'b1;
    #1;
    check("abort_hold", 32'(cpu_hold), 32'd1);
    check("abort_ready", 32'(bus.in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    step(1);
    init = 1'b0;
    step(4);
    check("abort_idle_ready", 32'(bus.in_ready), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_writes", 32'(wr_cnt - wr_base), 32'd2);
    bus.in_valid = 1'b0;

    // Fresh load after abort
    pulse_start();
    expect_write(0, 9'h077);
    send(9'd1);
    send(9'h077);
    bus.in_valid = 1'b0;
    step(1);
    check("post_abort_done", 32'(done), 32'd1);

    step(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
